// File: rtl/sram_like_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto one SRAM-like bus, one outstanding transaction.
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests; default favours the data master.
module sram_like_arbiter (
   input  logic        clk,
   input  logic        rst,
   // instruction master
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_addr_ok,
   output logic        i_data_ok,
   output logic [31:0] i_rdata,
   // data master
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [3:0]  d_sel,
   input  logic [2:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_addr_ok,
   output logic        d_data_ok,
   output logic [31:0] d_rdata,
   // shared bus
   output logic        req,
   output logic        wr,
   output logic [3:0]  select,
   output logic [2:0]  size,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

   state_t state_q, state_d;
   owner_t owner_q, owner_d;
   owner_t last_grant_q, last_grant_d;
   owner_t both_pick, grant_sel;
   logic   owner_req;
   logic   own_addr_ok, own_data_ok;

`ifdef ARB_ROUND_ROBIN_EN
   assign both_pick = (last_grant_q == OWN_D) ? OWN_I : OWN_D;
`else
   assign both_pick = OWN_D;
`endif

   assign grant_sel = (i_req && d_req) ? both_pick : (d_req ? OWN_D : OWN_I);
   assign owner_req = (owner_q == OWN_D) ? d_req : i_req;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_I;
         last_grant_q <= OWN_D;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      req          = 1'b0;
      own_addr_ok  = 1'b0;
      own_data_ok  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               owner_d      = grant_sel;
               last_grant_d = grant_sel;
               state_d      = ADDR;
            end
         end
         ADDR: begin
            // A flushed request is withdrawn from the bus in the same cycle it drops.
            if (!owner_req) begin
               state_d = IDLE;
            end else begin
               req = 1'b1;
               if (addr_ok) begin
                  own_addr_ok = 1'b1;
                  if (data_ok) begin
                     own_data_ok = 1'b1;
                     state_d     = IDLE;
                  end else begin
                     state_d = DATA;
                  end
               end
            end
         end
         DATA: begin
            if (data_ok) begin
               own_data_ok = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr     = (owner_q == OWN_D) ? d_wr    : 1'b0;
   assign select = (owner_q == OWN_D) ? d_sel   : 4'hF;
   assign size   = (owner_q == OWN_D) ? d_size  : 3'd2;
   assign addr   = (owner_q == OWN_D) ? d_addr  : i_addr;
   assign wdata  = (owner_q == OWN_D) ? d_wdata : 32'h0;

   assign i_addr_ok = own_addr_ok && (owner_q == OWN_I);
   assign i_data_ok = own_data_ok && (owner_q == OWN_I);
   assign d_addr_ok = own_addr_ok && (owner_q == OWN_D);
   assign d_data_ok = own_data_ok && (owner_q == OWN_D);
   assign i_rdata   = rdata;
   assign d_rdata   = rdata;

endmodule
